btn_debounce: RTL

- Per-button synchroniser, debouncer and edge detector for the raw push-button inputs of the lock datapath.
- Sits directly upstream of the level-to-pulse / lock FSM stage and replaces raw `b[1:0]` with clean levels and single-cycle press pulses.
- Runs on the fast board clock, so the lock can be clocked from the same domain rather than from a slow divided clock.

---
 rtl/btn_debounce.sv | 115 +++++++++++
 1 files changed

// File: rtl/btn_debounce.sv
// Per-button two-flop synchroniser, stability-counter debouncer and press/release edge pulses.
// Latency: STABLE_MAX+2 edges from first sampling of a stable change to btn_level and its pulse; no backpressure.
// Optional BTN_AUTOREPEAT_EN adds held-button repeat press pulses (REPEAT_DELAY, then every REPEAT_PERIOD).
module btn_debounce #(
    parameter int NBTN          = 2,
    parameter int CNT_BITS      = 20,
    parameter int STABLE_MAX    = 1000000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_in,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release
);

    localparam logic [CNT_BITS-1:0] CNT_TERM = CNT_BITS'(STABLE_MAX - 1);

    generate
        if (STABLE_MAX < 1 || STABLE_MAX > (2**CNT_BITS) - 1) begin : g_bad_stable
            $error("btn_debounce: STABLE_MAX does not fit CNT_BITS");
        end
        if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
            $error("btn_debounce: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
        end
    endgenerate

    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NBTN; i++) begin : g_btn
            logic [CNT_BITS-1:0] cnt;
            logic                level_q;
            logic                press_q;
            logic                rel_q;
            logic                differs;
            logic                term;
            logic                rep_fire;

            always_comb begin
                differs = (sync2[i] != level_q);
                term    = differs && (cnt == CNT_TERM);
            end

`ifdef BTN_AUTOREPEAT_EN
            localparam int HOLD_BITS = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
            localparam logic [HOLD_BITS-1:0] HOLD_FIRST = HOLD_BITS'(REPEAT_DELAY - 1);
            localparam logic [HOLD_BITS-1:0] HOLD_NEXT  = HOLD_BITS'(REPEAT_DELAY + REPEAT_PERIOD - 1);
            localparam logic [HOLD_BITS-1:0] HOLD_BASE  = HOLD_BITS'(REPEAT_DELAY);

            logic [HOLD_BITS-1:0] hold;

            // After the first repeat the counter cycles in [REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD-1].
            always_comb begin
                rep_fire = level_q && !term && ((hold == HOLD_FIRST) || (hold == HOLD_NEXT));
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hold <= '0;
                end else if (!level_q || term) begin
                    hold <= '0;
                end else if (rep_fire) begin
                    hold <= HOLD_BASE;
                end else begin
                    hold <= hold + HOLD_BITS'(1);
                end
            end
`else
            always_comb begin
                rep_fire = 1'b0;
            end
`endif

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt     <= '0;
                    level_q <= 1'b0;
                    press_q <= 1'b0;
                    rel_q   <= 1'b0;
                end else begin
                    press_q <= (term && sync2[i]) || rep_fire;
                    rel_q   <= term && !sync2[i];
                    if (!differs) begin
                        cnt <= '0;
                    end else if (term) begin
                        cnt     <= '0;
                        level_q <= sync2[i];
                    end else begin
                        cnt <= cnt + CNT_BITS'(1);
                    end
                end
            end

            assign btn_level[i]   = level_q;
            assign btn_press[i]   = press_q;
            assign btn_release[i] = rel_q;
        end
    endgenerate

endmodule
